// File: rtl/rr_arb32.sv
// rr_arb32: 32-way round-robin arbiter with hold-time limit, index and one-hot grant.
module dec5to32 (
    input  logic [4:0]  sel,
    output logic [31:0] y
);
    assign y = 32'(1) << sel;
endmodule

module rr_arb32 #(
    parameter int HOLD_W   = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    input  logic        done,
    output logic [31:0] gnt,
    output logic [4:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        expired
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    logic [0:0]        state;
    logic [4:0]        ptr;
    logic [4:0]        pick;
    logic [HOLD_W-1:0] cnt;
    logic [31:0]       dec;
    logic              rel_to;
    logic              rel;
    // Scan downward so the smallest offset from ptr wins.
    always_comb begin
        pick = ptr;
        for (int i = 31; i >= 0; i--)
            if (req[ptr + 5'(i)]) pick = ptr + 5'(i);
    end
    assign rel_to    = (HOLD_MAX != 0) && (cnt == HOLD_W'(HOLD_MAX - 1));
    assign rel       = done || !req[gnt_idx] || rel_to;
    assign gnt_valid = (state == GRANT);
    dec5to32 u_dec (.sel(gnt_idx), .y(dec));
    assign gnt = dec & {32{gnt_valid}};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            cnt     <= '0;
            expired <= 1'b0;
        end else if (state == IDLE) begin
            expired <= 1'b0;
            if (|req) begin
                gnt_idx <= pick;
                cnt     <= '0;
                state   <= GRANT;
            end
        end else if (rel) begin
            state   <= IDLE;
            ptr     <= gnt_idx + 5'd1;
            expired <= !done && req[gnt_idx];
        end else begin
            cnt     <= (cnt == '1) ? cnt : cnt + 1'b1;
            expired <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_arb32.sv
// tb_rr_arb32: vector table, directed corner sequences and random traffic against a reference model.
module tb_rr_arb32;
    localparam int HM = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req = '0;
    logic        done = 1'b0;
    logic [31:0] gnt;
    logic [4:0]  gnt_idx;
    logic        gnt_valid;
    logic        expired;
    int checks = 0;
    int errors = 0;
    // reference model state
    bit m_valid;
    int m_idx, m_ptr, m_held;
    bit m_exp;

    rr_arb32 #(.HOLD_W(8), .HOLD_MAX(HM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .expired(expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] req;
        logic        done;
        logic        v;
        logic [4:0]  idx;
        logic        ex;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input bit v, input int idx, input bit ex);
        logic [31:0] g;
        g = v ? (32'(1) << idx) : 32'd0;
        return {25'd0, g, 5'(idx), v, ex};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_exp = 0;
    endtask

    // One clock: advance the model from the pre-edge inputs, then compare after the edge.
    task automatic tick();
        bit nv, ne;
        int ni, np, nh;
        nv = m_valid; ni = m_idx; np = m_ptr; nh = m_held; ne = 0;
        if (m_valid) begin
            if (done || !req[m_idx] || (HM != 0 && m_held == HM)) begin
                nv = 0;
                np = (m_idx + 1) % 32;
                ne = !done && req[m_idx];
            end else nh = m_held + 1;
        end else if (req != 0) begin
            for (int k = 0; k < 32; k++)
                if (req[(m_ptr + k) % 32]) begin ni = (m_ptr + k) % 32; break; end
            nv = 1; nh = 1;
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_idx = ni; m_ptr = np; m_held = nh; m_exp = ne;
        chk("model", {25'd0, gnt, gnt_idx, gnt_valid, expired}, pack(m_valid, m_idx, m_exp));
    endtask

    task automatic do_reset();
        req = '0; done = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        tbl[0]  = '{32'h20, 0, 1, 5, 0};
        tbl[1]  = '{32'h20, 1, 0, 5, 0};
        tbl[2]  = '{32'h21, 0, 1, 0, 0};
        tbl[3]  = '{32'h21, 0, 1, 0, 0};
        tbl[4]  = '{32'h20, 0, 0, 0, 0};
        tbl[5]  = '{32'h21, 0, 1, 5, 0};
        tbl[6]  = '{32'h20, 0, 1, 5, 0};
        tbl[7]  = '{32'h20, 0, 1, 5, 0};
        tbl[8]  = '{32'h20, 0, 1, 5, 0};
        tbl[9]  = '{32'h20, 0, 0, 5, 1};
        tbl[10] = '{32'h00, 0, 0, 5, 0};
        tbl[11] = '{32'h00, 1, 0, 5, 0};

        model_reset();
        #12;
        chk("reset_state", {25'd0, gnt, gnt_idx, gnt_valid, expired}, pack(0, 0, 0));
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[i]) begin
            req = tbl[i].req; done = tbl[i].done;
            tick();
            chk($sformatf("tbl%0d", i), {25'd0, gnt, gnt_idx, gnt_valid, expired},
                pack(tbl[i].v, tbl[i].idx, tbl[i].ex));
        end

        // asynchronous reset mid-grant
        req = 32'h100; done = 0;
        tick();
        tick();
        chk("pre_reset_gnt", {32'd0, gnt}, 64'h100);
        rst_n = 0;
        #1;
        chk("async_reset", {25'd0, gnt, gnt_idx, gnt_valid, expired}, pack(0, 0, 0));
        model_reset();
        @(negedge clk);
        rst_n = 1;
        req = 32'h1;
        tick();
        chk("post_reset_idx0", {25'd0, gnt, gnt_idx, gnt_valid, expired}, pack(1, 0, 0));

        // fairness sweep from ptr=0
        do_reset();
        for (int n = 0; n <= 32; n++) begin
            req = '1; done = 0;
            tick();
            chk($sformatf("sweep%0d", n), {59'd0, gnt_idx}, 64'(n % 32));
            done = 1;
            tick();
            chk("sweep_rel", {63'd0, gnt_valid}, 64'd0);
        end
        done = 0;

        // wrap-around 30 -> 31 -> 0
        req = 32'h4000_0000;
        tick();
        chk("wrap30", {59'd0, gnt_idx}, 64'd30);
        done = 1; tick(); done = 0;
        req = 32'h8000_0001;
        tick();
        chk("wrap31", {59'd0, gnt_idx}, 64'd31);
        done = 1; tick(); done = 0;
        tick();
        chk("wrap0", {25'd0, gnt, gnt_idx, gnt_valid, expired}, pack(1, 0, 0));
        done = 1; tick(); done = 0;

        // timeout: grant 3 visible exactly HM cycles, then expired pulse, then grant 4
        req = 32'h18;
        for (int c = 0; c < HM; c++) begin
            tick();
            chk($sformatf("to_hold%0d", c), {32'd0, gnt}, 64'h8);
        end
        tick();
        chk("to_expire", {25'd0, gnt, gnt_idx, gnt_valid, expired}, pack(0, 3, 1));
        tick();
        chk("to_next", {25'd0, gnt, gnt_idx, gnt_valid, expired}, pack(1, 4, 0));
        done = 1; tick(); done = 0;

        // request drop by owner 7
        req = 32'h80;
        tick();
        tick();
        chk("drop_own", {59'd0, gnt_idx}, 64'd7);
        req = 32'h0;
        tick();
        chk("drop_rel", {25'd0, gnt, gnt_idx, gnt_valid, expired}, pack(0, 7, 0));
        req = 32'h180;
        tick();
        chk("drop_ptr8", {59'd0, gnt_idx}, 64'd8);
        done = 1; tick(); done = 0;

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = $urandom;
                default: req = $urandom & $urandom & $urandom;
            endcase
            done = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
